e_mdu: RTL and testbench

//  Multiply/divide unit of the execute stage. Sits beside the ALU, upstream of the E/M pipeline register.
//  - Executes mult/multu/div/divu with a fixed multi-cycle latency.
//  - Owns the HI/LO architectural registers and handles mthi/mtlo.
//  - Exposes HI/LO for mfhi/mflo; the E-stage result mux forwards them into the E/M register.
//  - busy_any drives the hazard unit's stall of MD-class instructions in D.

---
 rtl/md_pkg.sv | 29 ++
 rtl/e_mdu_if.sv | 26 ++
 rtl/e_mdu.sv | 147 ++++++++++++++
 tb/tb_e_mdu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and the result payload.
// Imported by e_mdu, the decode controller and the hazard unit.
package md_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  localparam int unsigned MD_DEFAULT_MULT_CYCLES = 5;
  localparam int unsigned MD_DEFAULT_DIV_CYCLES  = 10;

  // HI/LO pair produced by one multiply or divide
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  function automatic int unsigned md_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Execute-stage MD bus: issue side (start/md_op/operands) and HI/LO + busy return side.
//  master: controller/E-stage datapath (drives start, md_op, src_a, src_b)
//  slave : e_mdu (drives busy, busy_any, hi, lo)
interface e_mdu_if;
  import md_pkg::*;

  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [XLEN-1:0]    src_a;
  logic [XLEN-1:0]    src_b;
  logic               busy;
  logic               busy_any;
  logic [XLEN-1:0]    hi;
  logic [XLEN-1:0]    lo;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, busy_any, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, busy_any, hi, lo
  );

endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit of the execute stage; owns the HI/LO registers.
// Ports:
//  clk    - clock, all state on posedge
//  reset  - synchronous, active-high; aborts an in-flight op
//  bus    - e_mdu_if.slave: start/md_op/src_a/src_b in; busy (registered),
//           busy_any (combinational start|busy), hi, lo out
// A mult/div result is computed at the start edge into a pending register and
// committed to HI/LO on the edge the cycle counter reaches zero.
module e_mdu
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DEFAULT_DIV_CYCLES
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = md_max(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]      state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  md_result_t      pend_q,    pend_d;
  logic            pend_wr_q, pend_wr_d;
  logic [XLEN-1:0] hi_q,      hi_d;
  logic [XLEN-1:0] lo_q,      lo_d;

  // Arithmetic on the current operands
  logic [2*XLEN-1:0] a_sx, b_sx, prod_s, prod_u;
  logic              a_neg, b_neg, b_zero;
  logic [XLEN-1:0]   abs_a, abs_b, div_b_u, div_b_s;
  logic [XLEN-1:0]   uq, ur, sq_mag, sr_mag, sq, sr;

  always_comb begin
    a_sx   = {{XLEN{bus.src_a[XLEN-1]}}, bus.src_a};
    b_sx   = {{XLEN{bus.src_b[XLEN-1]}}, bus.src_b};
    // Low 2*XLEN bits of the sign-extended product equal the signed product
    prod_s = a_sx * b_sx;
    prod_u = {{XLEN{1'b0}}, bus.src_a} * {{XLEN{1'b0}}, bus.src_b};

    a_neg  = bus.src_a[XLEN-1];
    b_neg  = bus.src_b[XLEN-1];
    b_zero = (bus.src_b == '0);
    abs_a  = a_neg ? (~bus.src_a + XLEN'(1)) : bus.src_a;
    abs_b  = b_neg ? (~bus.src_b + XLEN'(1)) : bus.src_b;

    // Divisor forced to 1 on zero so the dividers never see x; result is discarded
    div_b_u = b_zero ? XLEN'(1) : bus.src_b;
    div_b_s = b_zero ? XLEN'(1) : abs_b;

    uq     = bus.src_a / div_b_u;
    ur     = bus.src_a % div_b_u;
    sq_mag = abs_a / div_b_s;
    sr_mag = abs_a % div_b_s;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    sq     = (a_neg ^ b_neg) ? (~sq_mag + XLEN'(1)) : sq_mag;
    sr     = a_neg ? (~sr_mag + XLEN'(1)) : sr_mag;
  end

  // Next-state and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            MD_MULT: begin
              state_d   = ST_BUSY;
              cnt_d     = CNT_W'(MULT_CYCLES);
              pend_d    = '{hi: prod_s[2*XLEN-1:XLEN], lo: prod_s[XLEN-1:0]};
              pend_wr_d = 1'b1;
            end
            MD_MULTU: begin
              state_d   = ST_BUSY;
              cnt_d     = CNT_W'(MULT_CYCLES);
              pend_d    = '{hi: prod_u[2*XLEN-1:XLEN], lo: prod_u[XLEN-1:0]};
              pend_wr_d = 1'b1;
            end
            MD_DIV: begin
              state_d   = ST_BUSY;
              cnt_d     = CNT_W'(DIV_CYCLES);
              pend_d    = '{hi: sr, lo: sq};
              pend_wr_d = !b_zero;
            end
            MD_DIVU: begin
              state_d   = ST_BUSY;
              cnt_d     = CNT_W'(DIV_CYCLES);
              pend_d    = '{hi: ur, lo: uq};
              pend_wr_d = !b_zero;
            end
            MD_MTHI: hi_d = bus.src_a;
            MD_MTLO: lo_d = bus.src_a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // Any start while busy is ignored
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy     = (state_q == ST_BUSY);
  assign bus.busy_any = bus.start | bus.busy;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed cases plus random ops against a longint reference model.
module tb_e_mdu;
  import md_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_cycles(input logic [2:0] op);
    case (op)
      MD_MULT, MD_MULTU: return MC;
      MD_DIV,  MD_DIVU:  return DC;
      default:           return 0;
    endcase
  endfunction

  // Reference: HI/LO after an accepted op, from plain 64-bit arithmetic
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
      MD_DIVU:  if (b != 0) begin q = ua / ub; r = ua % ub; m_hi = r[31:0]; m_lo = q[31:0]; end
      MD_MTHI:  m_hi = a;
      MD_MTLO:  m_lo = a;
      default:  ;
    endcase
  endfunction

  // Issue one op from idle (called #1 after a posedge), count busy cycles, check HI/LO.
  // With inject set, an mtlo and a mult are started during the 2nd and 3rd busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input string tag);
    int n;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    #1;
    chk({tag, ".busy_any"}, 32'(bus.busy_any), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    model(op, a, b);
    n = 0;
    while (bus.busy && n < 50) begin
      if (inject && n == 1) begin
        bus.start = 1'b1; bus.md_op = MD_MTLO; bus.src_a = 32'h0000_AAAA;
      end
      if (inject && n == 2) begin
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.src_a = $urandom; bus.src_b = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_cycles(op)));
    chk({tag, ".hi"}, bus.hi, m_hi);
    chk({tag, ".lo"}, bus.lo, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    bus.start = 1'b0;
    bus.md_op = MD_NOP;
    bus.src_a = '0;
    bus.src_b = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.busy_any", 32'(bus.busy_any), 32'd0);
    chk("reset.hi", bus.hi, 32'd0);
    chk("reset.lo", bus.lo, 32'd0);

    run_op(MD_MULT,  32'hFFFF_FFFB, 32'd3, 1'b0, "mult_neg");
    chk("mult_neg.lo_const", bus.lo, 32'hFFFF_FFF1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
    chk("multu.hi_const", bus.hi, 32'h0000_0001);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    chk("div_neg.lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op(MD_DIVU,  32'd7, 32'd2, 1'b0, "divu");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    chk("div_ovf.lo_const", bus.lo, 32'h8000_0000);
    run_op(MD_MTHI,  32'h0000_1234, 32'd0, 1'b0, "mthi");
    run_op(MD_DIV,   32'd5, 32'd0, 1'b0, "div_by0");
    chk("div_by0.hi_const", bus.hi, 32'h0000_1234);
    run_op(MD_MULT,  32'd6, 32'd7, 1'b1, "busy_inject");
    chk("busy_inject.lo_const", bus.lo, 32'd42);
    run_op(MD_MTLO,  32'h0000_AAAA, 32'd0, 1'b0, "mtlo_idle");
    run_op(MD_NOP,   32'hDEAD_BEEF, 32'd1, 1'b0, "nop0");
    run_op(3'd7,     32'hDEAD_BEEF, 32'd1, 1'b0, "nop7");

    // Reset in the 3rd busy cycle of a div aborts it
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.src_a = 32'd100; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("rst_abort.busy", 32'(bus.busy), 32'd0);
    chk("rst_abort.hi", bus.hi, 32'd0);
    chk("rst_abort.lo", bus.lo, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("rst_abort.hi_later", bus.hi, 32'd0);
    chk("rst_abort.lo_later", bus.lo, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_op(op, a, b, ($urandom_range(0, 3) == 0) && (exp_cycles(op) > 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
